// File: rtl/sram_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sram_access_ctrl                                                 |
// | Purpose  : Round-robin arbiter and phase sequencer for the 2-port sram_array |
// |            driven from Bennett clock phase edges.                           |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module sram_access_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int PHASES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkp,
  input  logic              rq0_valid,
  input  logic              rq0_we,
  input  logic [AW-1:0]     rq0_addrA,
  input  logic [AW-1:0]     rq0_addrB,
  input  logic [WIDTH-1:0]  rq0_wdata,
  output logic              rq0_ready,
  output logic              rq0_rvalid,
  input  logic              rq1_valid,
  input  logic              rq1_we,
  input  logic [AW-1:0]     rq1_addrA,
  input  logic [AW-1:0]     rq1_addrB,
  input  logic [WIDTH-1:0]  rq1_wdata,
  output logic              rq1_ready,
  output logic              rq1_rvalid,
  output logic [WIDTH-1:0]  rdataA,
  output logic [WIDTH-1:0]  rdataB,
  output logic              rerr,
  output logic [DEPTH-1:0]  wordA,
  output logic [DEPTH-1:0]  wordB,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic [WIDTH-1:0]  in,
  input  logic [WIDTH-1:0]  outA,
  input  logic [WIDTH-1:0]  outB,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_DATA   = 2'd2,
    S_ACCESS = 2'd3
  } ctrlState_t;

  function automatic logic [DEPTH-1:0] oneHot(input logic [AW-1:0] a);
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(a) == 32'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic inRange(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // State and registered outputs
  ctrlState_t        r_state;
  logic [PHASES-1:0] r_clkpPrev;
  logic              r_lastGrant;   // 1: rq1 was granted last
  logic              r_owner;
  logic              r_we;
  logic [AW-1:0]     r_addrA;
  logic [AW-1:0]     r_addrB;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_ready0;
  logic              r_ready1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_rerr;
  logic [WIDTH-1:0]  r_rdataA;
  logic [WIDTH-1:0]  r_rdataB;
  logic [DEPTH-1:0]  r_wordA;
  logic [DEPTH-1:0]  r_wordB;
  logic              r_readEn;
  logic              r_writeEn;
  logic [WIDTH-1:0]  r_in;
  logic              r_busy;

  // Next-state values
  ctrlState_t        w_stateNext;
  logic              w_lastGrantNext;
  logic              w_ownerNext;
  logic              w_weNext;
  logic [AW-1:0]     w_addrANext;
  logic [AW-1:0]     w_addrBNext;
  logic [WIDTH-1:0]  w_wdataNext;
  logic              w_ready0Next;
  logic              w_ready1Next;
  logic              w_rvalid0Next;
  logic              w_rvalid1Next;
  logic              w_rerrNext;
  logic [WIDTH-1:0]  w_rdataANext;
  logic [WIDTH-1:0]  w_rdataBNext;
  logic [DEPTH-1:0]  w_wordANext;
  logic [DEPTH-1:0]  w_wordBNext;
  logic              w_readEnNext;
  logic              w_writeEnNext;
  logic [WIDTH-1:0]  w_inNext;
  logic              w_busyNext;

  logic [PHASES-1:0] w_edge;
  logic              w_unusedEdges;
  logic              w_grant1;
  logic              w_selWe;
  logic [AW-1:0]     w_selAddrA;
  logic [AW-1:0]     w_selAddrB;
  logic [WIDTH-1:0]  w_selWdata;
  logic              w_selErr;

  // A phase edge is a rising level seen against the previous clk's sample
  assign w_edge        = clkp & ~r_clkpPrev;
  assign w_unusedEdges = ^w_edge;

  // Both valid: favour the requester that was not granted last
  assign w_grant1   = rq1_valid && (!rq0_valid || !r_lastGrant);
  assign w_selWe    = w_grant1 ? rq1_we    : rq0_we;
  assign w_selAddrA = w_grant1 ? rq1_addrA : rq0_addrA;
  assign w_selAddrB = w_grant1 ? rq1_addrB : rq0_addrB;
  assign w_selWdata = w_grant1 ? rq1_wdata : rq0_wdata;
  assign w_selErr   = !inRange(w_selAddrA) || (!w_selWe && !inRange(w_selAddrB));

  always_comb begin
    w_stateNext     = r_state;
    w_lastGrantNext = r_lastGrant;
    w_ownerNext     = r_owner;
    w_weNext        = r_we;
    w_addrANext     = r_addrA;
    w_addrBNext     = r_addrB;
    w_wdataNext     = r_wdata;
    w_ready0Next    = 1'b0;
    w_ready1Next    = 1'b0;
    w_rvalid0Next   = 1'b0;
    w_rvalid1Next   = 1'b0;
    w_rerrNext      = 1'b0;
    w_rdataANext    = r_rdataA;
    w_rdataBNext    = r_rdataB;
    w_wordANext     = r_wordA;
    w_wordBNext     = r_wordB;
    w_readEnNext    = r_readEn;
    w_writeEnNext   = r_writeEn;
    w_inNext        = r_in;
    w_busyNext      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_edge[1] && (rq0_valid || rq1_valid)) begin
          w_stateNext     = S_ADDR;
          w_lastGrantNext = w_grant1;
          w_ownerNext     = w_grant1;
          w_weNext        = w_selWe;
          w_addrANext     = w_selAddrA;
          w_addrBNext     = w_selAddrB;
          w_wdataNext     = w_selWdata;
          w_ready0Next    = !w_grant1;
          w_ready1Next    = w_grant1;
          w_rerrNext      = w_selErr;
          w_busyNext      = 1'b1;
        end
      end

      S_ADDR: begin
        if (w_edge[2]) begin
          w_stateNext = S_DATA;
          w_wordANext = oneHot(r_addrA);
          // Writes drive both ports onto the same row
          w_wordBNext = r_we ? oneHot(r_addrA) : oneHot(r_addrB);
        end
      end

      S_DATA: begin
        if (w_edge[4]) begin
          w_stateNext = S_ACCESS;
          w_inNext    = r_we ? r_wdata : '0;
        end
      end

      S_ACCESS: begin
        if (!r_we) begin
          if (w_edge[8]) begin
            w_stateNext   = S_IDLE;
            w_rdataANext  = outA;
            w_rdataBNext  = outB;
            w_rvalid0Next = !r_owner;
            w_rvalid1Next = r_owner;
            w_readEnNext  = 1'b0;
            w_wordANext   = '0;
            w_wordBNext   = '0;
            w_inNext      = '0;
            w_busyNext    = 1'b0;
          end else if (w_edge[6]) begin
            w_readEnNext = 1'b1;
          end
        end else begin
          if (w_edge[9]) begin
            w_stateNext   = S_IDLE;
            w_writeEnNext = 1'b0;
            w_wordANext   = '0;
            w_wordBNext   = '0;
            w_inNext      = '0;
            w_busyNext    = 1'b0;
          end else if (w_edge[8]) begin
            w_writeEnNext = 1'b1;
          end
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clkpPrev  <= '1;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addrA     <= '0;
      r_addrB     <= '0;
      r_wdata     <= '0;
      r_ready0    <= 1'b0;
      r_ready1    <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rerr      <= 1'b0;
      r_rdataA    <= '0;
      r_rdataB    <= '0;
      r_wordA     <= '0;
      r_wordB     <= '0;
      r_readEn    <= 1'b0;
      r_writeEn   <= 1'b0;
      r_in        <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_clkpPrev  <= clkp;
      r_lastGrant <= w_lastGrantNext;
      r_owner     <= w_ownerNext;
      r_we        <= w_weNext;
      r_addrA     <= w_addrANext;
      r_addrB     <= w_addrBNext;
      r_wdata     <= w_wdataNext;
      r_ready0    <= w_ready0Next;
      r_ready1    <= w_ready1Next;
      r_rvalid0   <= w_rvalid0Next;
      r_rvalid1   <= w_rvalid1Next;
      r_rerr      <= w_rerrNext;
      r_rdataA    <= w_rdataANext;
      r_rdataB    <= w_rdataBNext;
      r_wordA     <= w_wordANext;
      r_wordB     <= w_wordBNext;
      r_readEn    <= w_readEnNext;
      r_writeEn   <= w_writeEnNext;
      r_in        <= w_inNext;
      r_busy      <= w_busyNext;
    end
  end

  assign rq0_ready  = r_ready0;
  assign rq1_ready  = r_ready1;
  assign rq0_rvalid = r_rvalid0;
  assign rq1_rvalid = r_rvalid1;
  assign rerr       = r_rerr;
  assign rdataA     = r_rdataA;
  assign rdataB     = r_rdataB;
  assign wordA      = r_wordA;
  assign wordB      = r_wordB;
  assign ReadEn     = r_readEn;
  assign WriteEn    = r_writeEn;
  assign in         = r_in;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_sram_access_ctrl                                              |
// | Purpose  : Directed bench for sram_access_ctrl with a behavioural sram_array.|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_sram_access_ctrl;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int PHASES = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [PHASES-1:0] clkp;
  logic              rq0_valid, rq0_we, rq1_valid, rq1_we;
  logic [AW-1:0]     rq0_addrA, rq0_addrB, rq1_addrA, rq1_addrB;
  logic [WIDTH-1:0]  rq0_wdata, rq1_wdata;
  logic              rq0_ready, rq0_rvalid, rq1_ready, rq1_rvalid;
  logic [WIDTH-1:0]  rdataA, rdataB, sramIn, outA, outB;
  logic              rerr, ReadEn, WriteEn, busy;
  logic [DEPTH-1:0]  wordA, wordB;

  // Second build with a 16-word array sharing the same request stimulus
  logic              d2Ready0, d2Rvalid0, d2Ready1, d2Rvalid1, d2Rerr, d2ReadEn, d2WriteEn, d2Busy;
  logic [WIDTH-1:0]  d2RdataA, d2RdataB, d2In;
  logic [15:0]       d2WordA, d2WordB;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  sram_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .PHASES(PHASES)) dut (
    .clk(clk), .reset(reset), .clkp(clkp),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addrA(rq0_addrA), .rq0_addrB(rq0_addrB),
    .rq0_wdata(rq0_wdata), .rq0_ready(rq0_ready), .rq0_rvalid(rq0_rvalid),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addrA(rq1_addrA), .rq1_addrB(rq1_addrB),
    .rq1_wdata(rq1_wdata), .rq1_ready(rq1_ready), .rq1_rvalid(rq1_rvalid),
    .rdataA(rdataA), .rdataB(rdataB), .rerr(rerr), .wordA(wordA), .wordB(wordB),
    .ReadEn(ReadEn), .WriteEn(WriteEn), .in(sramIn), .outA(outA), .outB(outB), .busy(busy)
  );

  sram_access_ctrl #(.WIDTH(WIDTH), .DEPTH(16), .AW(AW), .PHASES(PHASES)) dut16 (
    .clk(clk), .reset(reset), .clkp(clkp),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addrA(rq0_addrA), .rq0_addrB(rq0_addrB),
    .rq0_wdata(rq0_wdata), .rq0_ready(d2Ready0), .rq0_rvalid(d2Rvalid0),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addrA(rq1_addrA), .rq1_addrB(rq1_addrB),
    .rq1_wdata(rq1_wdata), .rq1_ready(d2Ready1), .rq1_rvalid(d2Rvalid1),
    .rdataA(d2RdataA), .rdataB(d2RdataB), .rerr(d2Rerr), .wordA(d2WordA), .wordB(d2WordB),
    .ReadEn(d2ReadEn), .WriteEn(d2WriteEn), .in(d2In), .outA('0), .outB('0), .busy(d2Busy)
  );

  // Behavioural sram_array: combinational read while ReadEn, write on clk while WriteEn
  always_comb begin
    outA = '0;
    outB = '0;
    if (ReadEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wordA[i]) outA = outA | mem[i];
        if (wordB[i]) outB = outB | mem[i];
      end
    end
  end

  always @(posedge clk) begin
    if (WriteEn) begin
      for (int i = 0; i < DEPTH; i++) if (wordA[i]) mem[i] <= sramIn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic up(input int k);
    clkp[k] = 1'b1;
    tick();
  endtask

  task automatic downAll();
    for (int k = PHASES - 1; k >= 0; k--) begin
      clkp[k] = 1'b0;
      tick();
    end
  endtask

  task automatic setReq0(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [WIDTH-1:0] d);
    rq0_valid = 1'b1; rq0_we = we; rq0_addrA = a; rq0_addrB = b; rq0_wdata = d;
  endtask

  task automatic setReq1(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [WIDTH-1:0] d);
    rq1_valid = 1'b1; rq1_we = we; rq1_addrA = a; rq1_addrB = b; rq1_wdata = d;
  endtask

  // One full Bennett cycle; a requester drops valid once it has been accepted
  task automatic runCycle();
    for (int k = 0; k < PHASES; k++) begin
      up(k);
      if (k == 1) begin
        if (rq0_ready) rq0_valid = 1'b0;
        if (rq1_ready) rq1_valid = 1'b0;
      end
    end
    downAll();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clkp = '0;
    clkp[1] = 1'b1;
    setReq0(1'b1, 5'd4, 5'd0, 16'h5555);
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (wordA !== '0 || wordB !== '0) begin errors++; $display("FAIL reset_words: got %h/%h want 0/0", wordA, wordB); end
    checks++; if ({ReadEn, WriteEn, rerr} !== 3'b000) begin errors++; $display("FAIL reset_enables: got %b want 000", {ReadEn, WriteEn, rerr}); end
    checks++; if (rdataA !== '0 || sramIn !== '0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", rdataA, sramIn); end
    reset = 1'b0;
    tick();
    tick();
    checks++; if (rq0_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_high_phase: ready=%0b busy=%0b want 0/0", rq0_ready, busy); end
    rq0_valid = 1'b0;
    clkp = '0;
    tick();
  endtask

  task automatic test_write();
    setReq0(1'b1, 5'd1, 5'd0, 16'hAAAA);
    up(0);
    up(1);
    checks++; if ({rq0_ready, rq1_ready, rerr, busy} !== 4'b1001) begin errors++; $display("FAIL write_grant: r0,r1,err,busy=%b want 1001", {rq0_ready, rq1_ready, rerr, busy}); end
    rq0_valid = 1'b0;
    up(2);
    checks++; if (wordA !== 32'h2 || wordB !== 32'h2) begin errors++; $display("FAIL write_words: got %h/%h want 2/2", wordA, wordB); end
    checks++; if (rq0_ready !== 1'b0) begin errors++; $display("FAIL write_ready_pulse: got %0b want 0", rq0_ready); end
    up(3);
    up(4);
    checks++; if (sramIn !== 16'hAAAA) begin errors++; $display("FAIL write_in: got %h want aaaa", sramIn); end
    up(5);
    up(6);
    up(7);
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL write_en_early: got %0b want 0", WriteEn); end
    up(8);
    checks++; if (WriteEn !== 1'b1 || ReadEn !== 1'b0) begin errors++; $display("FAIL write_en_p8: we=%0b re=%0b want 1/0", WriteEn, ReadEn); end
    up(9);
    checks++; if ({WriteEn, busy} !== 2'b00 || wordA !== '0 || sramIn !== '0) begin errors++; $display("FAIL write_done: we=%0b busy=%0b wordA=%h in=%h want all 0", WriteEn, busy, wordA, sramIn); end
    checks++; if (mem[1] !== 16'hAAAA) begin errors++; $display("FAIL write_mem: got %h want aaaa", mem[1]); end
    downAll();
  endtask

  task automatic test_read();
    setReq0(1'b1, 5'd2, 5'd0, 16'hABCD);
    runCycle();
    checks++; if (mem[2] !== 16'hABCD) begin errors++; $display("FAIL read_setup_mem: got %h want abcd", mem[2]); end
    setReq1(1'b0, 5'd1, 5'd2, 16'h0);
    up(0);
    up(1);
    checks++; if ({rq0_ready, rq1_ready} !== 2'b01) begin errors++; $display("FAIL read_grant: r0,r1=%b want 01", {rq0_ready, rq1_ready}); end
    rq1_valid = 1'b0;
    up(2);
    checks++; if (wordA !== 32'h2 || wordB !== 32'h4) begin errors++; $display("FAIL read_words: got %h/%h want 2/4", wordA, wordB); end
    up(3);
    up(4);
    checks++; if (sramIn !== '0) begin errors++; $display("FAIL read_in: got %h want 0", sramIn); end
    up(5);
    up(6);
    checks++; if (ReadEn !== 1'b1) begin errors++; $display("FAIL read_en_p6: got %0b want 1", ReadEn); end
    up(7);
    checks++; if (ReadEn !== 1'b1 || rq1_rvalid !== 1'b0) begin errors++; $display("FAIL read_p7: re=%0b rv=%0b want 1/0", ReadEn, rq1_rvalid); end
    up(8);
    checks++; if (rdataA !== 16'hAAAA || rdataB !== 16'hABCD) begin errors++; $display("FAIL read_data: got %h/%h want aaaa/abcd", rdataA, rdataB); end
    checks++; if ({ReadEn, rq1_rvalid, rq0_rvalid} !== 3'b010) begin errors++; $display("FAIL read_p8: re,rv1,rv0=%b want 010", {ReadEn, rq1_rvalid, rq0_rvalid}); end
    up(9);
    checks++; if (rq1_rvalid !== 1'b0 || rdataA !== 16'hAAAA || busy !== 1'b0) begin errors++; $display("FAIL read_hold: rv=%0b rdA=%h busy=%0b want 0/aaaa/0", rq1_rvalid, rdataA, busy); end
    downAll();
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    logic exp1;
    setReq0(1'b0, 5'd1, 5'd2, 16'h0);
    setReq1(1'b0, 5'd2, 5'd1, 16'h0);
    for (int c = 0; c < 4; c++) begin
      exp1 = (c % 2) == 1;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < PHASES; k++) begin
        up(k);
        n0 += int'(rq0_ready);
        n1 += int'(rq1_ready);
        if (k == 8) begin
          checks++;
          if ({rq1_rvalid, rq0_rvalid} !== {exp1, !exp1} || rdataA !== (exp1 ? 16'hABCD : 16'hAAAA)) begin
            errors++; $display("FAIL b2b_rvalid c%0d: rv1,rv0=%b rdA=%h want %b%b", c, {rq1_rvalid, rq0_rvalid}, rdataA, exp1, !exp1);
          end
        end
      end
      checks++;
      if (n0 != (exp1 ? 0 : 1) || n1 != (exp1 ? 1 : 0)) begin
        errors++; $display("FAIL b2b_grants c%0d: ready0 x%0d ready1 x%0d want %0d/%0d", c, n0, n1, exp1 ? 0 : 1, exp1 ? 1 : 0);
      end
      downAll();
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  task automatic test_range();
    setReq0(1'b0, 5'd31, 5'd0, 16'h0);
    up(0);
    up(1);
    checks++; if (rq0_ready !== 1'b1 || rerr !== 1'b0) begin errors++; $display("FAIL range31_rerr: ready=%0b rerr=%0b want 1/0", rq0_ready, rerr); end
    rq0_valid = 1'b0;
    up(2);
    checks++; if (wordA !== 32'h8000_0000 || wordB !== 32'h1) begin errors++; $display("FAIL range31_words: got %h/%h want 80000000/1", wordA, wordB); end
    for (int k = 3; k < PHASES; k++) up(k);
    downAll();
    setReq0(1'b0, 5'd20, 5'd0, 16'h0);
    up(0);
    up(1);
    checks++; if (d2Ready0 !== 1'b1 || d2Rerr !== 1'b1 || rerr !== 1'b0) begin errors++; $display("FAIL range20_rerr: d16 ready=%0b rerr=%0b d32 rerr=%0b want 1/1/0", d2Ready0, d2Rerr, rerr); end
    rq0_valid = 1'b0;
    up(2);
    checks++; if (d2WordA !== 16'h0 || d2WordB !== 16'h1) begin errors++; $display("FAIL range20_words: got %h/%h want 0/1", d2WordA, d2WordB); end
    for (int k = 3; k < 9; k++) up(k);
    checks++; if (d2Rvalid0 !== 1'b1 || d2RdataA !== '0) begin errors++; $display("FAIL range20_rvalid: rv=%0b rdA=%h want 1/0", d2Rvalid0, d2RdataA); end
    up(9);
    downAll();
  endtask

  task automatic test_reset_access();
    setReq0(1'b0, 5'd1, 5'd2, 16'h0);
    up(0);
    up(1);
    rq0_valid = 1'b0;
    for (int k = 2; k < 7; k++) up(k);
    checks++; if (ReadEn !== 1'b1) begin errors++; $display("FAIL rst_acc_pre: ReadEn=%0b want 1", ReadEn); end
    reset = 1'b1;
    tick();
    checks++; if ({ReadEn, busy} !== 2'b00 || wordA !== '0 || wordB !== '0 || rdataA !== '0) begin errors++; $display("FAIL rst_acc_clear: re=%0b busy=%0b wA=%h wB=%h rdA=%h want 0", ReadEn, busy, wordA, wordB, rdataA); end
    reset = 1'b0;
    up(7);
    up(8);
    checks++; if (rq0_rvalid !== 1'b0 || ReadEn !== 1'b0) begin errors++; $display("FAIL rst_acc_norvalid: rv=%0b re=%0b want 0/0", rq0_rvalid, ReadEn); end
    up(9);
    downAll();
    setReq0(1'b0, 5'd2, 5'd1, 16'h0);
    setReq1(1'b0, 5'd1, 5'd1, 16'h0);
    up(0);
    up(1);
    checks++; if ({rq0_ready, rq1_ready} !== 2'b10) begin errors++; $display("FAIL rst_acc_rr: r0,r1=%b want 10", {rq0_ready, rq1_ready}); end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    for (int k = 2; k < 9; k++) up(k);
    checks++; if (rq0_rvalid !== 1'b1 || rdataA !== 16'hABCD || rdataB !== 16'hAAAA) begin errors++; $display("FAIL rst_acc_next: rv=%0b rd=%h/%h want 1 abcd/aaaa", rq0_rvalid, rdataA, rdataB); end
    up(9);
    downAll();
  endtask

  task automatic test_late_valid();
    logic sawWrite, sawBusy;
    up(0);
    up(1);
    checks++; if (rq0_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_idle: ready=%0b busy=%0b want 0/0", rq0_ready, busy); end
    setReq0(1'b1, 5'd3, 5'd0, 16'h1234);
    sawWrite = 1'b0;
    sawBusy = 1'b0;
    for (int k = 2; k < PHASES; k++) begin
      up(k);
      sawWrite |= WriteEn;
      sawBusy |= busy | rq0_ready;
    end
    checks++; if (sawWrite !== 1'b0 || sawBusy !== 1'b0 || mem[3] !== '0) begin errors++; $display("FAIL late_wait: we=%0b busy=%0b mem3=%h want 0/0/0", sawWrite, sawBusy, mem[3]); end
    downAll();
    up(0);
    up(1);
    checks++; if (rq0_ready !== 1'b1) begin errors++; $display("FAIL late_grant: ready=%0b want 1", rq0_ready); end
    rq0_valid = 1'b0;
    for (int k = 2; k < PHASES; k++) up(k);
    checks++; if (mem[3] !== 16'h1234) begin errors++; $display("FAIL late_mem: got %h want 1234", mem[3]); end
    downAll();
  endtask

  initial begin
    reset = 1'b1;
    clkp = '0;
    rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addrA = '0; rq0_addrB = '0; rq0_wdata = '0;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addrA = '0; rq1_addrB = '0; rq1_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_range();
    test_reset_access();
    test_late_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
